// File: rtl/stream_frame_gen.sv
// Framed K-symbol test-stream generator: SOF, length, payload (RAM/counter/PRBS7/zero), EOF, idle gap.
// Output byte is registered and held under back-pressure; the FSM only advances on an accepted transfer.
module stream_frame_gen #(
    parameter int         PAT_DEPTH = 32,
    parameter logic [6:0] PRBS_SEED = 7'h7F,
    localparam int        PAW       = $clog2(PAT_DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic [1:0]      mode_i,
    input  logic [7:0]      payload_len_i,
    input  logic [7:0]      gap_len_i,
    input  logic [15:0]     frame_cnt_i,
    input  logic            pat_we_i,
    input  logic [PAW-1:0]  pat_waddr_i,
    input  logic [7:0]      pat_wdata_i,
    input  logic            tx_ready_i,
    output logic            tx_valid_o,
    output logic [7:0]      tx_data_o,
    output logic            tx_isk_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     frames_sent_o
);
    // state   | meaning
    // S_IDLE  | no run, tx_valid low
    // S_SOF   | presenting K28.2
    // S_LEN   | presenting payload length byte
    // S_PAY   | presenting payload bytes
    // S_EOF   | presenting K28.1
    // S_GAP   | presenting K28.5 idle fill
    localparam logic [2:0] S_IDLE = 3'd0, S_SOF = 3'd1, S_LEN = 3'd2,
                           S_PAY  = 3'd3, S_EOF = 3'd4, S_GAP = 3'd5;
    localparam logic [7:0] K_SOF = 8'h5C, K_EOF = 8'h3C, K_IDL = 8'hBC;
    localparam logic [PAW-1:0] PTR_ONE = 1;

    logic [7:0]     pat_mem [PAT_DEPTH];
    logic [2:0]     state_q, state_d;
    logic           valid_q, valid_d, isk_q, isk_d, done_q, done_d, stop_q, stop_d;
    logic [7:0]     data_q, data_d, len_q, len_d, gap_q, gap_d, cnt_q, cnt_d, ctr_q, ctr_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    fcnt_q, fcnt_d, fs_q, fs_d, fs_end;
    logic [PAW-1:0] ptr_q, ptr_d;
    logic [6:0]     lfsr_q, lfsr_d;
    logic [14:0]    prbs_res;
    logic [7:0]     pay_byte;
    logic           xfer, emit_pay, emit_eof, frame_end;

    // Eight LFSR steps per byte; the first generated bit lands in the MSB.
    function automatic logic [14:0] prbs8(input logic [6:0] s_in);
        logic [6:0] s;
        logic [7:0] b;
        logic       fb;
        s = s_in;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            fb = s[6] ^ s[5];
            s  = {s[5:0], fb};
            b  = {b[6:0], fb};
        end
        return {b, s};
    endfunction

    always_ff @(posedge clk_i) begin
        if (pat_we_i) pat_mem[pat_waddr_i] <= pat_wdata_i;
    end

    always_comb begin
        prbs_res = prbs8(lfsr_q);
        case (mode_q)
            2'd0:    pay_byte = pat_mem[ptr_q];
            2'd1:    pay_byte = ctr_q;
            2'd2:    pay_byte = prbs_res[14:7];
            default: pay_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q; valid_d = valid_q; data_d = data_q; isk_d = isk_q;
        done_d  = 1'b0;    stop_d  = stop_q;  mode_d = mode_q; len_d = len_q;
        gap_d   = gap_q;   fcnt_d  = fcnt_q;  cnt_d  = cnt_q;  fs_d  = fs_q;
        ptr_d   = ptr_q;   ctr_d   = ctr_q;   lfsr_d = lfsr_q;
        emit_pay = 1'b0; emit_eof = 1'b0; frame_end = 1'b0; fs_end = fs_q;
        xfer = valid_q && tx_ready_i;

        if (state_q == S_IDLE) begin
            if (start_i) begin
                mode_d = mode_i; len_d = payload_len_i; gap_d = gap_len_i; fcnt_d = frame_cnt_i;
                fs_d = '0; ptr_d = '0; ctr_d = '0; lfsr_d = PRBS_SEED;
                stop_d  = stop_i;
                state_d = S_SOF; valid_d = 1'b1; data_d = K_SOF; isk_d = 1'b1;
            end
        end else begin
            if (stop_i) stop_d = 1'b1;
            if (xfer) begin
                case (state_q)
                    S_SOF: begin
                        state_d = S_LEN; data_d = len_q; isk_d = 1'b0;
                    end
                    S_LEN: begin
                        if (len_q != 8'd0) begin
                            emit_pay = 1'b1;
                            cnt_d    = len_q - 8'd1;
                        end else begin
                            emit_eof = 1'b1;
                        end
                    end
                    S_PAY: begin
                        if (cnt_q == 8'd0) emit_eof = 1'b1;
                        else begin
                            emit_pay = 1'b1;
                            cnt_d    = cnt_q - 8'd1;
                        end
                    end
                    S_EOF: begin
                        fs_d   = fs_q + 16'd1;
                        fs_end = fs_q + 16'd1;
                        if (gap_q != 8'd0) begin
                            state_d = S_GAP; data_d = K_IDL; isk_d = 1'b1;
                            cnt_d   = gap_q - 8'd1;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == 8'd0) frame_end = 1'b1;
                        else cnt_d = cnt_q - 8'd1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        if (emit_pay) begin
            state_d = S_PAY; data_d = pay_byte; isk_d = 1'b0;
            case (mode_q)
                2'd0:    ptr_d  = ptr_q + PTR_ONE;
                2'd1:    ctr_d  = ctr_q + 8'd1;
                2'd2:    lfsr_d = prbs_res[6:0];
                default: ;
            endcase
        end
        if (emit_eof) begin
            state_d = S_EOF; data_d = K_EOF; isk_d = 1'b1;
        end
        // Stop seen on this very cycle still counts toward ending after the current frame.
        if (frame_end) begin
            if (stop_q || stop_i || ((fcnt_q != 16'd0) && (fs_end == fcnt_q))) begin
                state_d = S_IDLE; valid_d = 1'b0; data_d = 8'h00; isk_d = 1'b0;
                done_d  = 1'b1;   stop_d  = 1'b0;
            end else begin
                state_d = S_SOF; data_d = K_SOF; isk_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE; valid_q <= 1'b0; data_q <= 8'h00; isk_q <= 1'b0;
            done_q  <= 1'b0;   stop_q  <= 1'b0; mode_q <= 2'd0;  len_q <= 8'h00;
            gap_q   <= 8'h00;  fcnt_q  <= '0;   cnt_q  <= 8'h00; fs_q  <= '0;
            ptr_q   <= '0;     ctr_q   <= 8'h00; lfsr_q <= PRBS_SEED;
        end else begin
            state_q <= state_d; valid_q <= valid_d; data_q <= data_d; isk_q <= isk_d;
            done_q  <= done_d;  stop_q  <= stop_d;  mode_q <= mode_d; len_q <= len_d;
            gap_q   <= gap_d;   fcnt_q  <= fcnt_d;  cnt_q  <= cnt_d;  fs_q  <= fs_d;
            ptr_q   <= ptr_d;   ctr_q   <= ctr_d;   lfsr_q <= lfsr_d;
        end
    end

    assign tx_valid_o    = valid_q;
    assign tx_data_o     = data_q;
    assign tx_isk_o      = isk_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign frames_sent_o = fs_q;
endmodule

// File: tb/tb_stream_frame_gen.sv
// Directed bench for stream_frame_gen: table of runs with hand-computed symbol streams, plus reset corner cases.
module tb_stream_frame_gen;
    logic        clk = 1'b0;
    logic        rst, start, stop, pat_we, tx_ready;
    logic [1:0]  mode, pat_waddr;
    logic [7:0]  payload_len, gap_len, pat_wdata;
    logic [15:0] frame_cnt;
    logic        tx_valid, tx_isk, busy, done;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_frame_gen #(.PAT_DEPTH(4), .PRBS_SEED(7'h7F)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_i(mode),
        .payload_len_i(payload_len), .gap_len_i(gap_len), .frame_cnt_i(frame_cnt),
        .pat_we_i(pat_we), .pat_waddr_i(pat_waddr), .pat_wdata_i(pat_wdata),
        .tx_ready_i(tx_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_isk_o(tx_isk),
        .busy_o(busy), .done_o(done), .frames_sent_o(frames_sent)
    );

    typedef struct { logic [7:0] d; logic k; } sym_t;
    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  len;
        logic [7:0]  gap;
        logic [15:0] fcnt;
        bit          rnd;
        bit          ss;
        int          stop_at;
        int          wr_idx;
        bit          load;
        logic [31:0] ram;
        int          first;
        int          n;
        logic [15:0] frames;
    } row_t;

    sym_t exp_q[$];
    row_t rows[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // v[8] is the K flag, v[7:0] the byte: 9'h15C = K28.2, 9'h004 = data 0x04.
    function automatic void p(input logic [8:0] v);
        sym_t s;
        s.d = v[7:0];
        s.k = v[8];
        exp_q.push_back(s);
    endfunction

    function automatic void p_cnt_frame(input logic [7:0] len, input logic [7:0] gap, input logic [7:0] first);
        p(9'h15C);
        p({1'b0, len});
        for (int i = 0; i < int'(len); i++) p({1'b0, first + 8'(i)});
        p(9'h13C);
        for (int i = 0; i < int'(gap); i++) p(9'h1BC);
    endfunction

    function automatic void add_row(input logic [1:0] m, input logic [7:0] l, input logic [7:0] g,
                                    input logic [15:0] c, input bit rnd, input bit ss, input int stop_at,
                                    input int wr_idx, input bit load, input logic [31:0] ram,
                                    input int first, input int n, input logic [15:0] frames);
        row_t w;
        w.mode = m; w.len = l; w.gap = g; w.fcnt = c; w.rnd = rnd; w.ss = ss;
        w.stop_at = stop_at; w.wr_idx = wr_idx; w.load = load; w.ram = ram;
        w.first = first; w.n = n; w.frames = frames;
        rows.push_back(w);
    endfunction

    task automatic run_row(input int r);
        row_t w;
        sym_t e;
        int   acc, dones;
        bit   prev_stall, stop_done, start_done, wr_done, rdy;
        logic [7:0] pd;
        logic       pk;
        w = rows[r];
        if (w.load) begin
            for (int a = 0; a < 4; a++) begin
                pat_we = 1'b1; pat_waddr = a[1:0]; pat_wdata = w.ram[31-8*a -: 8];
                @(negedge clk);
            end
            pat_we = 1'b0;
        end
        mode = w.mode; payload_len = w.len; gap_len = w.gap; frame_cnt = w.fcnt;
        tx_ready = 1'b1; start = 1'b1; stop = w.ss;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        // Scramble the inputs after start; the run must use the captured copies.
        mode = ~w.mode; payload_len = 8'hFF; gap_len = 8'hFF; frame_cnt = 16'h0001;
        chk($sformatf("row%0d busy_after_start", r), busy, 1);
        acc = 0; dones = 0; prev_stall = 0; stop_done = 0; start_done = 0; wr_done = 0;
        pd = '0; pk = 1'b0;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            if (done) dones++;
            if (prev_stall) begin
                chk($sformatf("row%0d stall_data", r), tx_data, pd);
                chk($sformatf("row%0d stall_isk", r), tx_isk, pk);
            end
            rdy = w.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            tx_ready = rdy;
            stop = 1'b0; start = 1'b0; pat_we = 1'b0;
            if (!stop_done && acc == w.stop_at) begin stop = 1'b1; stop_done = 1; end
            if (!start_done && acc == 5 && busy) begin start = 1'b1; start_done = 1; end
            if (tx_valid && rdy) begin
                if (!wr_done && acc == w.wr_idx) begin
                    pat_we = 1'b1; pat_waddr = 2'd0; pat_wdata = 8'h22; wr_done = 1;
                end
                if (acc < w.n) begin
                    e = exp_q[w.first + acc];
                    chk($sformatf("row%0d byte%0d data", r, acc), tx_data, e.d);
                    chk($sformatf("row%0d byte%0d isk", r, acc), tx_isk, e.k);
                end else begin
                    chk($sformatf("row%0d extra_byte", r), acc, w.n);
                end
                acc++;
            end
            prev_stall = tx_valid && !rdy;
            pd = tx_data; pk = tx_isk;
            @(negedge clk);
        end
        stop = 1'b0; start = 1'b0; pat_we = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk($sformatf("row%0d done_once", r), dones, 1);
        chk($sformatf("row%0d byte_count", r), acc, w.n);
        chk($sformatf("row%0d frames_sent", r), frames_sent, w.frames);
        chk($sformatf("row%0d busy_end", r), busy, 0);
        chk($sformatf("row%0d valid_end", r), tx_valid, 0);
    endtask

    initial begin
        int f, f1;
        bit found;
        int dn;

        // Scenario 1: counter payload, two frames.
        f1 = exp_q.size();
        p(9'h15C); p(9'h004); p(9'h000); p(9'h001); p(9'h002); p(9'h003); p(9'h13C); p(9'h1BC); p(9'h1BC);
        p(9'h15C); p(9'h004); p(9'h004); p(9'h005); p(9'h006); p(9'h007); p(9'h13C); p(9'h1BC); p(9'h1BC);
        add_row(2'd1, 8'd4, 8'd2, 16'd2, 0, 0, -1, -1, 0, 32'h0, f1, 18, 16'd2);
        add_row(2'd1, 8'd4, 8'd2, 16'd2, 1, 0, -1, -1, 0, 32'h0, f1, 18, 16'd2);
        f = exp_q.size();
        p(9'h15C); p(9'h001); p(9'h002); p(9'h13C);
        add_row(2'd2, 8'd1, 8'd0, 16'd1, 0, 0, -1, -1, 0, 32'h0, f, 4, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h002); p(9'h002); p(9'h00C); p(9'h13C); p(9'h1BC);
        add_row(2'd2, 8'd2, 8'd1, 16'd1, 0, 0, -1, -1, 0, 32'h0, f, 6, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h003); p(9'h000); p(9'h000); p(9'h000); p(9'h13C);
        add_row(2'd3, 8'd3, 8'd0, 16'd1, 0, 0, -1, -1, 0, 32'h0, f, 6, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h000); p(9'h13C); p(9'h1BC);
        add_row(2'd1, 8'd0, 8'd1, 16'd1, 0, 0, -1, -1, 0, 32'h0, f, 4, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h006); p(9'h0DE); p(9'h0AD); p(9'h0BE); p(9'h0EF); p(9'h0DE); p(9'h0AD); p(9'h13C);
        add_row(2'd0, 8'd6, 8'd0, 16'd1, 0, 0, -1, -1, 1, 32'hDEADBEEF, f, 9, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h004); p(9'h0BC); p(9'h05C); p(9'h03C); p(9'h000); p(9'h13C); p(9'h1BC);
        add_row(2'd0, 8'd4, 8'd1, 16'd1, 0, 0, -1, -1, 1, 32'hBC5C3C00, f, 8, 16'd1);
        // RAM write coinciding with the read of the same address yields the old byte.
        f = exp_q.size();
        p(9'h15C); p(9'h001); p(9'h011); p(9'h13C);
        add_row(2'd0, 8'd1, 8'd0, 16'd1, 0, 0, -1, 1, 1, 32'h11334455, f, 4, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h001); p(9'h022); p(9'h13C);
        add_row(2'd0, 8'd1, 8'd0, 16'd1, 0, 0, -1, -1, 0, 32'h0, f, 4, 16'd1);
        f = exp_q.size();
        p(9'h15C); p(9'h001); p(9'h000); p(9'h13C); p(9'h1BC);
        add_row(2'd3, 8'd1, 8'd1, 16'd0, 0, 1, -1, -1, 0, 32'h0, f, 5, 16'd1);
        // Infinite run stopped during frame 3's payload.
        f = exp_q.size();
        p_cnt_frame(8'd4, 8'd2, 8'h00); p_cnt_frame(8'd4, 8'd2, 8'h04); p_cnt_frame(8'd4, 8'd2, 8'h08);
        add_row(2'd1, 8'd4, 8'd2, 16'd0, 0, 0, 21, -1, 0, 32'h0, f, 27, 16'd3);

        rst = 1'b1; start = 1'b0; stop = 1'b0; pat_we = 1'b0; tx_ready = 1'b1;
        mode = 2'd0; pat_waddr = 2'd0; pat_wdata = 8'h00;
        payload_len = 8'd0; gap_len = 8'd0; frame_cnt = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset tx_isk", tx_isk, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset frames_sent", frames_sent, 0);

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_in_idle busy", busy, 0);

        for (int r = 0; r < rows.size(); r++) run_row(r);

        // Reset in the middle of a payload.
        mode = 2'd1; payload_len = 8'd4; gap_len = 8'd0; frame_cnt = 16'd1; tx_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx_valid && !tx_isk && tx_data == 8'h01) found = 1;
            else @(negedge clk);
        end
        chk("rst_mid reached_payload", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid tx_valid", tx_valid, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid frames_sent", frames_sent, 0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("rst_mid no_done", dn, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart first_data", tx_data, 8'h5C);
        chk("restart first_isk", tx_isk, 1);
        chk("restart first_valid", tx_valid, 1);
        @(negedge clk);
        chk("restart len", tx_data, 8'h04);
        @(negedge clk);
        chk("restart payload0", tx_data, 8'h00);
        dn = 0;
        for (int i = 0; i < 30 && dn == 0; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("restart done", dn, 1);
        chk("restart frames_sent", frames_sent, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
